// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared constants and types for the write-through data cache.
//   - WR_*    : store-size flag encoding (shared with the data RAM)
//   - LD_*    : load-size field encoding, flag[1:0]; LD_SIGN is the
//               sign-extend bit position, flag[2]
//   - state_t : cache controller state
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_WORD = 2'b01;
  localparam logic [1:0] WR_HALF = 2'b10;
  localparam logic [1:0] WR_BYTE = 2'b11;

  localparam logic [1:0] LD_NONE = 2'b00;
  localparam logic [1:0] LD_WORD = 2'b01;
  localparam logic [1:0] LD_HALF = 2'b10;
  localparam logic [1:0] LD_BYTE = 2'b11;
  localparam int         LD_SIGN = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

endpackage

// File: rtl/dcache_wt_if.sv
// -----------------------------------------------------------------------------
// dcache_wt_if
// Bundles the front-side request/response signals and the back-side RAM
// signals of the data cache.
//   cpu_addr/cpu_wdata/cpu_write_flag/cpu_load_flag : MEM stage request
//   cpu_rdata/stall                                 : response to MEM stage
//   mem_addr/mem_wdata/mem_write_flag/mem_load_flag : RAM request
//   mem_rdata                                       : RAM combinational data
// Modports:
//   slave  : the cache itself
//   master : the environment (pipeline + RAM)
// -----------------------------------------------------------------------------
interface dcache_wt_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [1:0]        cpu_write_flag;
  logic [2:0]        cpu_load_flag;
  logic [31:0]       cpu_rdata;
  logic              stall;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        mem_write_flag;
  logic [2:0]        mem_load_flag;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_write_flag, cpu_load_flag, mem_rdata,
    output cpu_rdata, stall, mem_addr, mem_wdata, mem_write_flag, mem_load_flag
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_write_flag, cpu_load_flag, mem_rdata,
    input  cpu_rdata, stall, mem_addr, mem_wdata, mem_write_flag, mem_load_flag
  );

endinterface

// File: rtl/dcache_subword.sv
// -----------------------------------------------------------------------------
// dcache_subword
// Purely combinational sub-word helper for the data cache.
//   load_word   in  32 : cached word being read
//   load_flag   in  3  : [1:0] size, [2] sign-extend
//   load_data   out 32 : extracted and extended load result (0 for LD_NONE)
//   old_word    in  32 : cached word being stored into
//   store_data  in  32 : store data from the pipeline
//   write_flag  in  2  : store size
//   merged_word out 32 : old_word with the low half/byte (or all) replaced
// -----------------------------------------------------------------------------
module dcache_subword
  import dcache_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [2:0]  load_flag,
  output logic [31:0] load_data,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  input  logic [1:0]  write_flag,
  output logic [31:0] merged_word
);

  logic sign_en;

  assign sign_en = load_flag[LD_SIGN];

  always_comb begin
    load_data = 32'd0;
    case (load_flag[1:0])
      LD_WORD: load_data = load_word;
      LD_HALF: load_data = {{16{sign_en & load_word[15]}}, load_word[15:0]};
      LD_BYTE: load_data = {{24{sign_en & load_word[7]}}, load_word[7:0]};
      LD_NONE: load_data = 32'd0;
      default: load_data = 32'd0;
    endcase
  end

  // Sub-word stores always land in the low bits; upper bits keep their value.
  always_comb begin
    merged_word = old_word;
    case (write_flag)
      WR_WORD: merged_word = store_data;
      WR_HALF: merged_word = {old_word[31:16], store_data[15:0]};
      WR_BYTE: merged_word = {old_word[31:8], store_data[7:0]};
      WR_NONE: merged_word = old_word;
      default: merged_word = old_word;
    endcase
  end

endmodule

// File: rtl/dcache_wt.sv
// -----------------------------------------------------------------------------
// dcache_wt
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the MEM stage and a word-addressed RAM with combinational reads.
//   clk   in : clock, all state on rising edge
//   rst   in : synchronous active-high reset
//   bus      : dcache_wt_if.slave (front-side request/response, RAM side)
// Optional (macro DCACHE_STATS_EN):
//   hit_count  out 32 : IDLE load hits, replay after refill excluded, saturating
//   miss_count out 32 : refills started, saturating
// Parameters: ADDR_W word-address width, LINES lines, LINE_WORDS words/line.
// -----------------------------------------------------------------------------
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINES      = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  dcache_wt_if.slave  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  state_t            state;
  logic [OFF_W-1:0]  cnt;
  logic [ADDR_W-1:0] base_addr;
  logic              replay;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags      [LINES];
  logic [31:0]       line_data [LINES][LINE_WORDS];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  ref_idx;
  logic [TAG_W-1:0]  ref_tag;

  logic              is_store;
  logic              is_load;
  logic              hit;
  logic              last_word;
  logic [31:0]       cur_word;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  assign off = bus.cpu_addr[OFF_W-1:0];
  assign idx = bus.cpu_addr[OFF_W +: IDX_W];
  assign tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];

  assign ref_idx = base_addr[OFF_W +: IDX_W];
  assign ref_tag = base_addr[ADDR_W-1 -: TAG_W];

  // A request carrying both flags is a store; its load half is dropped.
  assign is_store  = (bus.cpu_write_flag != WR_NONE);
  assign is_load   = (bus.cpu_load_flag[1:0] != LD_NONE) && !is_store;
  assign hit       = valid[idx] && (tags[idx] == tag);
  assign last_word = (cnt == OFF_W'(LINE_WORDS - 1));
  assign cur_word  = line_data[idx][off];

  dcache_subword u_subword (
    .load_word   (cur_word),
    .load_flag   (bus.cpu_load_flag),
    .load_data   (load_data),
    .old_word    (cur_word),
    .store_data  (bus.cpu_wdata),
    .write_flag  (bus.cpu_write_flag),
    .merged_word (merged_word)
  );

  // Front and back side outputs. Reset forces everything quiet even if the
  // state register still says REFILL, and a load miss stalls in the same
  // cycle it is seen so the pipeline never consumes a bogus result.
  always_comb begin
    bus.stall          = 1'b0;
    bus.cpu_rdata      = 32'd0;
    bus.mem_addr       = bus.cpu_addr;
    bus.mem_wdata      = bus.cpu_wdata;
    bus.mem_write_flag = WR_NONE;
    bus.mem_load_flag  = 3'b000;
    if (rst) begin
      bus.stall = 1'b0;
    end else if (state == REFILL) begin
      bus.stall         = 1'b1;
      bus.mem_addr      = base_addr + ADDR_W'(cnt);
      bus.mem_load_flag = {1'b0, LD_WORD};
    end else if (is_store) begin
      bus.mem_write_flag = bus.cpu_write_flag;
    end else if (is_load) begin
      if (hit) begin
        bus.cpu_rdata = load_data;
      end else begin
        bus.stall = 1'b1;
      end
    end
  end

  // Controller: detects load misses, walks the refill counter across the
  // line and installs the tag once the last word lands. replay marks the
  // cycle right after a refill, when the stalled load re-executes as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      valid  <= '0;
      replay <= 1'b0;
    end else begin
      replay <= 1'b0;
      case (state)
        IDLE: begin
          if (is_load && !hit) begin
            base_addr <= {bus.cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            cnt       <= '0;
            state     <= REFILL;
          end
        end
        REFILL: begin
          cnt <= cnt + OFF_W'(1);
          if (last_word) begin
            valid[ref_idx] <= 1'b1;
            tags[ref_idx]  <= ref_tag;
            replay         <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; valid bits alone decide whether it counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == REFILL) begin
        line_data[ref_idx][cnt] <= bus.mem_rdata;
      end else if (is_store && hit) begin
        line_data[idx][off] <= merged_word;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating event counters; stores are deliberately not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else if (state == IDLE && is_load) begin
      if (hit && !replay && hit_count != 32'hFFFF_FFFF) begin
        hit_count <= hit_count + 32'd1;
      end
      if (!hit && miss_count != 32'hFFFF_FFFF) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// -----------------------------------------------------------------------------
// tb_dcache_wt
// Directed bench for dcache_wt with a small word-addressed RAM model behind
// it. Expected values are hand-computed constants. Optional counters are
// checked when DCACHE_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_dcache_wt;

  logic        clk;
  logic        rst;
  int          checks;
  int          failures;
  logic [31:0] ram [256];

  dcache_wt_if #(.ADDR_W(32)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_wt #(
    .ADDR_W     (32),
    .LINES      (8),
    .LINE_WORDS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: combinational read, write with byte/half merge on the clock edge.
  assign bus.mem_rdata = ram[bus.mem_addr[7:0]];

  always @(posedge clk) begin
    case (bus.mem_write_flag)
      2'b01: ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      2'b10: ram[bus.mem_addr[7:0]] <= {ram[bus.mem_addr[7:0]][31:16], bus.mem_wdata[15:0]};
      2'b11: ram[bus.mem_addr[7:0]] <= {ram[bus.mem_addr[7:0]][31:8], bus.mem_wdata[7:0]};
      default: ;
    endcase
  end

  // Drive one request just after a rising edge, then let outputs settle.
  task automatic applyStimulus(input logic r, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] wflag,
                               input logic [2:0] lflag);
    @(posedge clk);
    #1;
    rst                = r;
    bus.cpu_addr       = addr;
    bus.cpu_wdata      = wdata;
    bus.cpu_write_flag = wflag;
    bus.cpu_load_flag  = lflag;
    #1;
  endtask

  // Hold inputs and move to the settled point of the next cycle.
  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    ram[8'h10] = 32'h1234_5678;
    ram[8'h11] = 32'h8000_F0F0;
    ram[8'h12] = 32'hA5A5_0012;
    ram[8'h13] = 32'h1313_1313;
    ram[8'h30] = 32'hCAFE_0030;
    ram[8'h31] = 32'hCAFE_0031;
    ram[8'h32] = 32'hCAFE_0032;
    ram[8'h33] = 32'hCAFE_0033;

    rst                = 1'b1;
    bus.cpu_addr       = 32'd0;
    bus.cpu_wdata      = 32'd0;
    bus.cpu_write_flag = 2'b00;
    bus.cpu_load_flag  = 3'b000;

    // Reset held with a load pending: everything must stay quiet.
    applyStimulus(1'b1, 32'h10, 32'd0, 2'b00, 3'b001);
    checkOutput("rst_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("rst_mem_load_flag", {29'd0, bus.mem_load_flag}, 32'd0);
    checkOutput("rst_mem_write_flag", {30'd0, bus.mem_write_flag}, 32'd0);
    checkOutput("rst_rdata", bus.cpu_rdata, 32'd0);
    applyStimulus(1'b1, 32'h10, 32'd0, 2'b00, 3'b001);
`ifdef DCACHE_STATS_EN
    checkOutput("rst_hit_count", hit_count, 32'd0);
    checkOutput("rst_miss_count", miss_count, 32'd0);
`endif

    // 1: cold word load 0x10 -> miss cycle + 4 refill cycles, then hit.
    applyStimulus(1'b0, 32'h10, 32'd0, 2'b00, 3'b001);
    checkOutput("t1_miss_stall", {31'd0, bus.stall}, 32'd1);
    checkOutput("t1_miss_ldflag", {29'd0, bus.mem_load_flag}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      waitCycle();
      checkOutput("t1_refill_stall", {31'd0, bus.stall}, 32'd1);
      checkOutput("t1_refill_addr", bus.mem_addr, 32'h10 + i);
      checkOutput("t1_refill_ldflag", {29'd0, bus.mem_load_flag}, 32'd1);
    end
    waitCycle();
    checkOutput("t1_replay_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("t1_replay_rdata", bus.cpu_rdata, 32'h1234_5678);

    // 2: half loads from 0x11, signed and unsigned.
    applyStimulus(1'b0, 32'h11, 32'd0, 2'b00, 3'b110);
    checkOutput("t2_hs_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("t2_hs_ldflag", {29'd0, bus.mem_load_flag}, 32'd0);
    checkOutput("t2_hs_rdata", bus.cpu_rdata, 32'hFFFF_F0F0);
    applyStimulus(1'b0, 32'h11, 32'd0, 2'b00, 3'b010);
    checkOutput("t2_hu_rdata", bus.cpu_rdata, 32'h0000_F0F0);

    // 3: byte store 0xAB to 0x10, then reads back through the cache.
    applyStimulus(1'b0, 32'h10, 32'h0000_00AB, 2'b11, 3'b000);
    checkOutput("t3_st_wflag", {30'd0, bus.mem_write_flag}, 32'd3);
    checkOutput("t3_st_addr", bus.mem_addr, 32'h10);
    checkOutput("t3_st_wdata", bus.mem_wdata, 32'h0000_00AB);
    checkOutput("t3_st_stall", {31'd0, bus.stall}, 32'd0);
    applyStimulus(1'b0, 32'h10, 32'd0, 2'b00, 3'b111);
    checkOutput("t3_bs_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("t3_bs_rdata", bus.cpu_rdata, 32'hFFFF_FFAB);
    applyStimulus(1'b0, 32'h10, 32'd0, 2'b00, 3'b001);
    checkOutput("t3_w_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("t3_w_rdata", bus.cpu_rdata, 32'h1234_56AB);
    // Store and load together: the load is dropped.
    applyStimulus(1'b0, 32'h10, 32'h0000_00AB, 2'b11, 3'b001);
    checkOutput("t3_both_rdata", bus.cpu_rdata, 32'd0);
    checkOutput("t3_both_wflag", {30'd0, bus.mem_write_flag}, 32'd3);
    checkOutput("t3_both_stall", {31'd0, bus.stall}, 32'd0);

    // 4: 0x30 shares index with 0x10 -> evicts it; 0x10 then misses again.
    applyStimulus(1'b0, 32'h30, 32'd0, 2'b00, 3'b001);
    checkOutput("t4_miss30_stall", {31'd0, bus.stall}, 32'd1);
    waitCycle();
    checkOutput("t4_refill30_addr0", bus.mem_addr, 32'h30);
    waitCycle();
    waitCycle();
    waitCycle();
    checkOutput("t4_refill30_addr3", bus.mem_addr, 32'h33);
    waitCycle();
    checkOutput("t4_replay30_rdata", bus.cpu_rdata, 32'hCAFE_0030);
    checkOutput("t4_replay30_stall", {31'd0, bus.stall}, 32'd0);
    applyStimulus(1'b0, 32'h10, 32'd0, 2'b00, 3'b001);
    checkOutput("t4_miss10_stall", {31'd0, bus.stall}, 32'd1);
    for (int i = 0; i < 4; i++) waitCycle();
    checkOutput("t4_refill10_last_stall", {31'd0, bus.stall}, 32'd1);
    waitCycle();
    checkOutput("t4_replay10_rdata", bus.cpu_rdata, 32'h1234_56AB);

    // 5: word store to absent 0x50 -> write-through only, no allocation.
    applyStimulus(1'b0, 32'h50, 32'hDEAD_BEEF, 2'b01, 3'b000);
    checkOutput("t5_st_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("t5_st_wflag", {30'd0, bus.mem_write_flag}, 32'd1);
    checkOutput("t5_st_addr", bus.mem_addr, 32'h50);
    checkOutput("t5_st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h10, 32'd0, 2'b00, 3'b001);
    checkOutput("t5_keep10_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("t5_keep10_rdata", bus.cpu_rdata, 32'h1234_56AB);
    applyStimulus(1'b0, 32'h50, 32'd0, 2'b00, 3'b001);
    checkOutput("t5_miss50_stall", {31'd0, bus.stall}, 32'd1);
    for (int i = 0; i < 4; i++) waitCycle();
    waitCycle();
    checkOutput("t5_replay50_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("t5_replay50_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);

    // Idle: no request -> flags quiet, address passes through.
    applyStimulus(1'b0, 32'h77, 32'd0, 2'b00, 3'b000);
    checkOutput("idle_wflag", {30'd0, bus.mem_write_flag}, 32'd0);
    checkOutput("idle_ldflag", {29'd0, bus.mem_load_flag}, 32'd0);
    checkOutput("idle_addr", bus.mem_addr, 32'h77);
    checkOutput("idle_stall", {31'd0, bus.stall}, 32'd0);
`ifdef DCACHE_STATS_EN
    checkOutput("t5_hit_count", hit_count, 32'd5);
    checkOutput("t5_miss_count", miss_count, 32'd4);
`endif

    // 6: reset during the second refill cycle discards everything.
    applyStimulus(1'b0, 32'h30, 32'd0, 2'b00, 3'b001);
    checkOutput("t6_miss_stall", {31'd0, bus.stall}, 32'd1);
    waitCycle();
    checkOutput("t6_refill_addr0", bus.mem_addr, 32'h30);
    applyStimulus(1'b1, 32'h30, 32'd0, 2'b00, 3'b001);
    checkOutput("t6_rst_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("t6_rst_ldflag", {29'd0, bus.mem_load_flag}, 32'd0);
    applyStimulus(1'b0, 32'h50, 32'd0, 2'b00, 3'b000);
    checkOutput("t6_post_rst_stall", {31'd0, bus.stall}, 32'd0);
`ifdef DCACHE_STATS_EN
    checkOutput("t6_hit_count", hit_count, 32'd0);
    checkOutput("t6_miss_count", miss_count, 32'd0);
`endif
    // 0x50 was resident before the reset; it must miss now.
    applyStimulus(1'b0, 32'h50, 32'd0, 2'b00, 3'b001);
    checkOutput("t6_miss50_stall", {31'd0, bus.stall}, 32'd1);
    waitCycle();
    checkOutput("t6_refill50_addr0", bus.mem_addr, 32'h50);
`ifdef DCACHE_STATS_EN
    checkOutput("t6_miss_count_after", miss_count, 32'd1);
`endif
    waitCycle();
    waitCycle();
    waitCycle();
    waitCycle();
    checkOutput("t6_replay50_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    // 0x10 was evicted by 0x50 and must refill with the stored byte.
    applyStimulus(1'b0, 32'h10, 32'd0, 2'b00, 3'b001);
    checkOutput("t6_miss10_stall", {31'd0, bus.stall}, 32'd1);
    for (int i = 0; i < 4; i++) waitCycle();
    waitCycle();
    checkOutput("t6_replay10_rdata", bus.cpu_rdata, 32'h1234_56AB);
    checkOutput("t6_replay10_stall", {31'd0, bus.stall}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the word-addressed data RAM.
- Front side takes the same store/load flag encoding the RAM uses; back side drives the RAM's address, write data and flags directly.
- Load misses refill a whole line from RAM, one word per cycle, while the cache holds the pipeline stalled.
- Store hits update the line; every store is forwarded to RAM in the same cycle.

Parameters:
- ADDR_W, 32, word-address width (front and back)
- LINES, 8, number of cache lines (power of two)
- LINE_WORDS, 4, 32-bit words per line (power of two, >=2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- cpu_addr  in  ADDR_W  word address from MEM stage
- cpu_wdata  in  32  store data
- cpu_write_flag  in  2  00 none, 01 word, 10 half [15:0], 11 byte [7:0]
- cpu_load_flag  in  3  [1:0]: 00 none, 01 word, 10 half, 11 byte; [2]=1 sign-extend
- cpu_rdata  out  32  load result, combinational
- stall  out  1  freeze pipeline while high
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- mem_write_flag  out  2  RAM write flag, same encoding as cpu_write_flag
- mem_load_flag  out  3  RAM load flag
- mem_rdata  in  32  RAM combinational read data

Behaviour:
- Address split: offset = low log2(LINE_WORDS) bits; index = next log2(LINES) bits; tag = the rest.
- Storage: per line a valid bit, a tag and LINE_WORDS data words, all in flops.
- Reset: all valid=0, state=IDLE, refill counter=0. While rst is high: stall=0, mem_* flags=0, cpu_rdata=0.
- FSM has two states, IDLE and REFILL.
- IDLE, load hit (valid and tag match):
  - cpu_rdata returns the extracted word in the same cycle; stall=0; mem_load_flag=000.
- IDLE, load miss:
  - stall=1 combinationally in that cycle; latch the line base address; counter=0; next state REFILL.
- REFILL:
  - stall=1.
  - mem_addr = line_base + counter; mem_load_flag=001.
  - Each edge writes mem_rdata into word[counter] and increments counter.
  - After word LINE_WORDS-1 is written: set valid and tag, return to IDLE.
  - The next cycle replays the load as a hit, so a miss costs LINE_WORDS+1 cycles with stall high for LINE_WORDS+1 cycles.
- Sub-word load:
  - Half = word[15:0]; byte = word[7:0].
  - Sign source is bit 15 (half) or bit 7 (byte) when flag[2]=1; zero-extend otherwise.
  - Load flag 00 gives cpu_rdata=0.
- Store, IDLE only:
  - mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_write_flag=cpu_write_flag in the same cycle; stall=0.
  - On hit, the same edge merges the low half or byte into the cached word; upper bits are unchanged.
  - On miss, no allocation and no tag/valid change.
- Load and store flags both nonzero: treated as a store; load ignored; cpu_rdata=0.
- Inputs are ignored while in REFILL; the pipeline holds them stable under stall.
- Idle outputs: with no request, mem_write_flag=00, mem_load_flag=000, mem_addr=cpu_addr.
- rst mid-refill: the partial line is discarded and valid cleared; stall=0 in the cycle after rst deasserts, unless that cycle's request misses.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Enabled:
  - Adds outputs hit_count[31:0] and miss_count[31:0], cleared by rst.
  - hit_count increments once per IDLE load hit, excluding the replay cycle after a refill.
  - miss_count increments once per refill start.
  - Store hits and misses are not counted; both counters saturate at 0xFFFFFFFF.
- Disabled: the ports and counters are absent.

Decomposition:
- Package dcache_pkg:
  - Write-flag constants WR_NONE/WR_WORD/WR_HALF/WR_BYTE.
  - Load-size constants LD_NONE/LD_WORD/LD_HALF/LD_BYTE and the LD_SIGN bit position.
  - State enum {IDLE, REFILL}.
- Sub-module dcache_subword, purely combinational:
  - Load extraction/extension.
  - Store merge of a half or byte into an existing word.

Test Plan (defaults; RAM word 0x10 holds 0x12345678, 0x11 holds 0x8000F0F0):
1. After reset, word load 0x10 -> stall=1 for 5 cycles; mem_addr 0x10,0x11,0x12,0x13 with mem_load_flag=001; then cpu_rdata=0x12345678, stall=0.
2. Half load signed 0x11 -> hit, no stall, mem_load_flag=000, cpu_rdata=0xFFFFF0F0; the unsigned form returns 0x0000F0F0.
3. Store byte 0xAB to 0x10 -> same cycle mem_write_flag=11, mem_addr=0x10, no stall; then signed byte load 0x10 -> 0xFFFFFFAB, and word load -> 0x123456AB with no miss.
4. Word load 0x30 (same index as 0x10) -> refill, evicts line; word load 0x10 -> misses again and refills.
5. Word store 0xDEADBEEF to 0x50 with line absent -> written through, no stall, no allocation; load 0x50 -> misses and returns 0xDEADBEEF.
6. rst pulsed on the second REFILL cycle -> stall=0 after release, valid cleared; with DCACHE_STATS_EN, hit_count=0 and miss_count=0, and a following load 0x10 gives a miss with miss_count=1.
